ps2_key_decoder: RTL and testbench

- Receives device-to-host PS/2 keyboard frames on the raw ps2_clk/ps2_data pins.
- Decodes set-2 scan-code sequences, including the E0 extended prefix and the F0 break prefix.
- Emits one-cycle key-press and key-release strobes carrying the 8-bit make code.
- Sits between the keyboard pins and the control blocks (octave select, note mapping); those blocks act on any nonzero key value.

---
 rtl/ps2_key_decoder_pkg.sv | 17 +
 rtl/ps2_key_decoder_if.sv | 10 +
 rtl/ps2_key_decoder_line_filter.sv | 44 ++++
 rtl/ps2_key_decoder.sv | 143 ++++++++++++++
 tb/tb_ps2_key_decoder.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/ps2_key_decoder_pkg.sv
// Shared PS/2 set-2 scan-code constants and frame helpers for the keyboard front end.
package ps2_key_decoder_pkg;

  localparam logic [7:0] ps2_lshift     = 8'h12;
  localparam logic [7:0] ps2_rshift     = 8'h59;
  localparam logic [7:0] ps2_space      = 8'h29;
  localparam logic [7:0] ps2_prefix_ext = 8'hE0;
  localparam logic [7:0] ps2_prefix_brk = 8'hF0;
  localparam logic [7:0] ps2_overrun_lo = 8'h00;
  localparam logic [7:0] ps2_overrun_hi = 8'hFF;

  // PS/2 uses odd parity over the data byte plus the parity bit
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Key event bundle from the decoder to the control blocks (octave select, note mapping).
interface ps2_key_decoder_if;
  logic [7:0] key;
  logic       key_ext;
  logic [7:0] key_up;
  logic       frame_err;

  modport master (output key, key_ext, key_up, frame_err);
  modport slave  (input  key, key_ext, key_up, frame_err);
endinterface

// File: rtl/ps2_key_decoder_line_filter.sv
// Pin conditioning: 2-FF synchronizers, glitch filter on ps2_clk, falling-edge strobe.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic data
);
  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    clk_sync, dat_sync;
  logic          filt;
  logic [CW-1:0] cnt;

  // filt only follows the synchronized clock after FILTER_LEN differing samples in a row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      filt     <= 1'b1;
      cnt      <= '0;
      fall     <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      fall     <= 1'b0;
      if (clk_sync[1] == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        filt <= clk_sync[1];
        cnt  <= '0;
        fall <= filt;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign data = dat_sync[1];

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 device-to-host frame receiver plus set-2 make/break/extended sequence decoder.
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
#(
  parameter int CLK_HZ         = 100_000_000,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  ps2_key_decoder_if.master  evt
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  if (CLK_HZ < 1 || FILTER_LEN < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("ps2_key_decoder: illegal parameter value");
  end

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          fall, sdata;
  state_t        state, state_nx;
  logic [2:0]    bit_cnt, bit_cnt_nx;
  logic [7:0]    shreg, shreg_nx;
  logic          par, par_nx;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit, byte_vld, frame_bad;

  logic [7:0]    key_q, key_up_q, held;
  logic          key_ext_q, frame_err_q, ext, brk;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
    .clk     (clk),
    .rst     (rst),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .fall    (fall),
    .data    (sdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      state   <= state_nx;
      bit_cnt <= bit_cnt_nx;
      shreg   <= shreg_nx;
      par     <= par_nx;
      tmo_cnt <= (state == IDLE || fall || tmo_hit) ? '0 : tmo_cnt + 1'b1;
    end
  end

  // Timeout fires on the TIMEOUT_CYCLES-th fall-free cycle after the last fall
  assign tmo_hit = (state != IDLE) && !fall && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    par_nx     = par;
    byte_vld   = 1'b0;
    frame_bad  = 1'b0;
    if (tmo_hit) begin
      state_nx  = IDLE;
      frame_bad = 1'b1;
    end else if (fall) begin
      unique case (state)
        IDLE: if (!sdata) begin
          state_nx   = DATA;
          bit_cnt_nx = '0;
        end
        DATA: begin
          shreg_nx   = {sdata, shreg[7:1]};
          bit_cnt_nx = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state_nx = PARITY;
        end
        PARITY: begin
          par_nx   = sdata;
          state_nx = STOP;
        end
        STOP: begin
          state_nx = IDLE;
          if (sdata && odd_parity_ok(shreg, par)) byte_vld  = 1'b1;
          else                                    frame_bad = 1'b1;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Sequence decoder: prefixes arm ext/brk, held suppresses typematic repeats
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q       <= '0;
      key_ext_q   <= 1'b0;
      key_up_q    <= '0;
      frame_err_q <= 1'b0;
      ext         <= 1'b0;
      brk         <= 1'b0;
      held        <= '0;
    end else begin
      key_q       <= '0;
      key_ext_q   <= 1'b0;
      key_up_q    <= '0;
      frame_err_q <= frame_bad;
      if (frame_bad) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (byte_vld) begin
        if (shreg == ps2_prefix_ext) begin
          ext <= 1'b1;
        end else if (shreg == ps2_prefix_brk) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (shreg == ps2_overrun_lo || shreg == ps2_overrun_hi) begin
            // overrun marker carries no key
          end else if (brk) begin
            key_up_q <= shreg;
            if (held == shreg) held <= '0;
          end else if (shreg != held) begin
            key_q     <= shreg;
            key_ext_q <= ext;
            held      <= shreg;
          end
        end
      end
    end
  end

  assign evt.key       = key_q;
  assign evt.key_ext   = key_ext_q;
  assign evt.key_up    = key_up_q;
  assign evt.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: bit-banged PS/2 frames, event log, latency checks.
module tb_ps2_key_decoder;
  localparam int FL  = 8;
  localparam int TMO = 300;
  localparam int LAT = FL + 3;  // pin fall -> output pulse, in clk cycles

  logic clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  ps2_key_decoder_if evt_if();

  ps2_key_decoder #(.CLK_HZ(100_000_000), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .evt(evt_if)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int cyc = 0, fall_cyc = 0, err_cnt = 0, err_cyc = 0, both_cnt = 0;
  logic [8:0] key_q[$];
  int         key_cyc_q[$];
  logic [7:0] up_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (!rst) begin
    if (evt_if.key != 0) begin
      key_q.push_back({evt_if.key_ext, evt_if.key});
      key_cyc_q.push_back(cyc);
    end
    if (evt_if.key_up != 0) up_q.push_back(evt_if.key_up);
    if (evt_if.frame_err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (evt_if.key != 0 && evt_if.key_up != 0) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wt(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    key_q.delete();
    key_cyc_q.delete();
    up_q.delete();
    err_cnt = 0;
  endtask

  // Frame bits LSB first: start, 8 data, parity, stop; nbits < 11 truncates the frame
  task automatic send_byte(input logic [7:0] b, input bit bad_par = 0, input bit bad_stop = 0,
                           input bit glitch = 0, input int nbits = 11);
    logic [10:0] fr;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      if (glitch && i == 4) begin
        wt(3); ps2_clk = 1'b0; wt(3); ps2_clk = 1'b1; wt(4);
      end else begin
        wt(10);
      end
      ps2_clk  = 1'b0;
      fall_cyc = cyc;
      wt(20);
      ps2_clk = 1'b1;
      wt(10);
    end
  endtask

  function automatic logic [8:0] kq(input int i);
    return (key_q.size() > i) ? key_q[i] : 9'h1ff;
  endfunction

  function automatic logic [7:0] uq(input int i);
    return (up_q.size() > i) ? up_q[i] : 8'hee;
  endfunction

  initial begin
    bit seen;
    wt(5);
    chk("rst_key", evt_if.key, 0);
    chk("rst_key_ext", evt_if.key_ext, 0);
    chk("rst_key_up", evt_if.key_up, 0);
    chk("rst_frame_err", evt_if.frame_err, 0);
    rst = 1'b0;
    wt(20);

    // single make 0x12
    clr();
    send_byte(8'h12);
    chk("t1_nkey", key_q.size(), 1);
    chk("t1_key", kq(0), {1'b0, 8'h12});
    chk("t1_lat", (key_cyc_q.size() > 0) ? key_cyc_q[0] - fall_cyc : -1, LAT);
    chk("t1_nup", up_q.size(), 0);
    chk("t1_nerr", err_cnt, 0);

    // typematic suppression and release
    clr();
    send_byte(8'h29); send_byte(8'h29); send_byte(8'h29);
    send_byte(8'hF0); send_byte(8'h29); send_byte(8'h29);
    chk("t2_nkey", key_q.size(), 2);
    chk("t2_key0", kq(0), {1'b0, 8'h29});
    chk("t2_key1", kq(1), {1'b0, 8'h29});
    chk("t2_nup", up_q.size(), 1);
    chk("t2_up0", uq(0), 8'h29);

    // parity error then recovery
    clr();
    send_byte(8'h12, 1);
    chk("t3_perr", err_cnt, 1);
    chk("t3_nkey", key_q.size(), 0);
    send_byte(8'h59);
    chk("t3_key", kq(0), {1'b0, 8'h59});
    chk("t3_nerr", err_cnt, 1);

    // extended make / extended break
    clr();
    send_byte(8'hE0); send_byte(8'h75);
    chk("t4_nkey", key_q.size(), 1);
    chk("t4_key", kq(0), {1'b1, 8'h75});
    clr();
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    chk("t4_up", uq(0), 8'h75);
    chk("t4_nup", up_q.size(), 1);
    chk("t4_nkey_brk", key_q.size(), 0);

    // overrun byte is dropped silently
    clr();
    send_byte(8'hFF);
    chk("t5_ovr_nkey", key_q.size(), 0);
    chk("t5_ovr_nerr", err_cnt, 0);

    // timeout after five bits
    clr();
    send_byte(8'h33, 0, 0, 0, 5);
    seen = 0;
    for (int i = 0; i < TMO + 100 && !seen; i++) begin
      wt(1);
      if (err_cnt != 0) seen = 1;
    end
    chk("t6_tmo_seen", seen, 1);
    chk("t6_tmo_lat", err_cyc - fall_cyc, FL + TMO + 3);
    wt(20);
    chk("t6_tmo_nerr", err_cnt, 1);
    send_byte(8'h29);
    chk("t6_key", kq(0), {1'b0, 8'h29});
    chk("t6_nkey", key_q.size(), 1);

    // short low glitch on ps2_clk mid-frame
    clr();
    send_byte(8'h12, 0, 0, 1);
    chk("t7_key", kq(0), {1'b0, 8'h12});
    chk("t7_nerr", err_cnt, 0);

    // bad stop bit
    clr();
    send_byte(8'h59, 0, 1);
    chk("t8_serr", err_cnt, 1);
    chk("t8_nkey", key_q.size(), 0);

    // reset mid-frame
    clr();
    send_byte(8'h44, 0, 0, 0, 4);
    rst = 1'b1;
    wt(3);
    chk("t9_rst_key", evt_if.key, 0);
    chk("t9_rst_up", evt_if.key_up, 0);
    chk("t9_rst_err", evt_if.frame_err, 0);
    ps2_data = 1'b1;
    rst = 1'b0;
    wt(TMO + 50);
    chk("t9_nerr", err_cnt, 0);
    send_byte(8'h59);
    chk("t9_nkey", key_q.size(), 1);
    chk("t9_key", kq(0), {1'b0, 8'h59});

    chk("key_up_exclusive", both_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
